// File: rtl/demux_sched_pkg.sv
// Package: demux_sched_pkg
// Shared constants, FSM state encoding and helpers for the 1:8 demux scheduler.
// The optional delivery counters are enabled by defining DEMUX_SCHED_CNT_EN.

package demux_sched_pkg;

    localparam int NUM_DST = 8;
    localparam int SEL_W   = 3;

    // FSM state encoding kept as plain constants so older tools and
    // hand-written waveform decoders see stable values.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PEND = 2'd1;
    localparam state_t ST_SEND = 2'd2;

    // The round-robin pointer starts at the top so the first grant lands on
    // destination 0.
    localparam logic [SEL_W-1:0] LAST_PTR_RST = 3'd7;

    // Select code to one-hot destination valid.
    function automatic logic [NUM_DST-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_DST-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Module: rr_pick_8
// Combinational round-robin picker over eight requesters. The search starts
// one place after the most recently served index and wraps around.

module rr_pick_8
    import demux_sched_pkg::*;
(
    input  logic [NUM_DST-1:0] req_i,
    input  logic [SEL_W-1:0]   last_ptr_i,
    output logic               gnt_vld_o,
    output logic [SEL_W-1:0]   gnt_idx_o
);

    logic [SEL_W-1:0] cand;
    logic             found;

    // Walk the eight candidates in rotated order and keep the first requester.
    always_comb begin
        cand      = '0;
        found     = 1'b0;
        gnt_idx_o = '0;
        for (int i = 1; i <= NUM_DST; i++) begin
            cand = last_ptr_i + SEL_W'(i);
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                gnt_idx_o = cand;
            end
        end
        gnt_vld_o = found;
    end

endmodule

// File: rtl/demux_1_8_sched_v.sv
// Module: demux_1_8_sched_v
// Scheduler for the 1:8 demux datapath: accepts one word at a time, picks a
// ready and enabled destination round-robin, and holds the word until that
// destination takes it. Define DEMUX_SCHED_CNT_EN to add per-destination
// delivery counters on o_cnt.

module demux_1_8_sched_v
    import demux_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_ready,
    input  logic [NUM_DST-1:0]       i_dst_en,
    input  logic [NUM_DST-1:0]       i_dst_ready,
    output logic [SEL_W-1:0]         o_sel_code,
    output logic [NUM_DST-1:0]       o_valid,
    output logic [DATA_W-1:0]        o_data
`ifdef DEMUX_SCHED_CNT_EN
    ,
    output logic [NUM_DST*CNT_W-1:0] o_cnt
`endif
);

    state_t              state_q,    state_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic [SEL_W-1:0]    sel_q,      sel_d;
    logic [NUM_DST-1:0]  valid_q,    valid_d;
    logic [SEL_W-1:0]    last_ptr_q, last_ptr_d;

    logic [NUM_DST-1:0]  elig;
    logic                gnt_vld;
    logic [SEL_W-1:0]    gnt_idx;
    logic                sel_ready;
    logic                xfer;

    assign elig      = i_dst_en & i_dst_ready;
    assign sel_ready = i_dst_ready[sel_q];
    assign xfer      = (state_q == ST_SEND) && sel_ready;

    rr_pick_8 u_pick (
        .req_i      (elig),
        .last_ptr_i (last_ptr_q),
        .gnt_vld_o  (gnt_vld),
        .gnt_idx_o  (gnt_idx)
    );

    // Upstream ready: free in IDLE, and in SEND only on the cycle the held word leaves.
    always_comb begin
        o_ready = 1'b0;
        case (state_q)
            ST_IDLE: o_ready = 1'b1;
            ST_PEND: o_ready = 1'b0;
            ST_SEND: o_ready = sel_ready;
            default: o_ready = 1'b0;
        endcase
    end

    // Next-state logic: capture, grant, then hold until the chosen destination accepts.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    data_d  = i_data;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (gnt_vld) begin
                    sel_d   = gnt_idx;
                    valid_d = sel_to_onehot(gnt_idx);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    valid_d    = '0;
                    last_ptr_d = sel_q;
                    if (i_valid) begin
                        data_d  = i_data;
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any held word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            sel_q      <= '0;
            valid_q    <= '0;
            last_ptr_q <= LAST_PTR_RST;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    assign o_sel_code = sel_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;

`ifdef DEMUX_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_DST];

    // Per-destination delivery counters, wrapping, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_DST; k++) begin
                cnt_q[k] <= '0;
            end
        end else if (xfer) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_DST; g++) begin : g_cnt_out
        assign o_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule
